wishbone_ram_slave: RTL and testbench
=====================================

Name: wishbone_ram_slave

Overview:
- Wishbone slave-side responder: a word-organised RAM endpoint that attaches to one slave port of the wishbone interconnect.
- Accepts single classic-cycle reads and writes (CYC/STB/WE/SEL) and inserts a programmable number of wait states.
- Ends every accepted transfer with exactly one registered ACK or ERR pulse (RTY optional).
- Addresses arrive already offset by the interconnect, so the block's byte address 0 is its base.

Parameters:
- TAGSIZE, 1, width of the tag buses (tga/tgd/tgc).
- DEPTH, 256, number of 32-bit words; power of two, at least 2.
- WAIT_STATES, 0, idle cycles between request acceptance and the response pulse; 0..15.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- wb_dat_i  input  32  write data.
- wb_tgd_i  input  TAGSIZE  write-data tag; ignored.
- wb_adr_i  input  32  byte address, relative to the slave base.
- wb_tga_i  input  TAGSIZE  address tag; captured on accept.
- wb_cyc_i  input  1  cycle in progress.
- wb_tgc_i  input  TAGSIZE  cycle tag; ignored.
- wb_sel_i  input  4  byte lane enables; bit k covers dat[8k+7:8k].
- wb_stb_i  input  1  strobe.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_dat_o  output  32  read data.
- wb_tgd_o  output  TAGSIZE  read-data tag; equals the captured wb_tga_i.
- wb_ack_o  output  1  normal termination.
- wb_err_o  output  1  error termination.
- wb_rty_o  output  1  retry termination; constant 0 unless WB_RAM_RTY_EN is defined.
- busy_i  input  1  present only with WB_RAM_RTY_EN; high = RAM unavailable.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, wait counter 0. RAM contents are not reset.
- Reset mid-transfer: the FSM returns to IDLE immediately. No write is committed and no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE, request acceptance:
  - A request is accepted when wb_cyc_i & wb_stb_i.
  - On accept, capture adr, we, sel, dat, tga.
  - Error condition: adr[1:0] != 0, or adr[31:2] >= DEPTH.
  - If the error condition holds, go to RESP with error flagged.
  - Else if WAIT_STATES == 0, go to RESP.
  - Else load counter = WAIT_STATES - 1 and go to WAIT.
- WAIT:
  - If wb_cyc_i drops, go to IDLE: abort, no access, no response.
  - Else if counter == 0, go to RESP.
  - Else decrement the counter.
- RESP:
  - Lasts exactly one cycle. Exactly one of ack/err/rty is high in this cycle; all are 0 in every other state.
  - Next state is always IDLE.
  - A new request may be accepted in the cycle after RESP, so back-to-back transfers take WAIT_STATES + 2 cycles each.
- Latency: the response appears WAIT_STATES + 1 cycles after the accept edge (1 cycle when WAIT_STATES = 0).
- Write:
  - Committed on the clock edge that enters RESP.
  - Only lanes with sel = 1 are written; sel = 0000 acks with no change.
  - wb_dat_o is 0 during a write response.
- Read:
  - wb_dat_o is registered and valid only during the RESP cycle; it is 0 otherwise.
  - Returns the full word regardless of sel.
  - A read always returns the value from the most recently committed write.
- Error response: no RAM access, wb_dat_o = 0, wb_tgd_o still echoes the captured tag.
- Word index = adr[log2(DEPTH)+1:2].
- Requests presented while in WAIT or RESP are not re-sampled; the master holds stb until the response per protocol.

Optional Feature:
- Macro WB_RAM_RTY_EN.
- Defined:
  - Port busy_i exists and is sampled only at accept in IDLE.
  - If busy_i = 1 and the address is valid, skip WAIT and go straight to RESP with wb_rty_o = 1: no access, dat = 0.
  - ERR has priority over RTY.
- Undefined: busy_i port absent, wb_rty_o tied to 0.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to adr 0x10 with sel=1111, then read adr 0x10 -> ack one cycle after each accept; read dat_o = 0xDEADBEEF, err = rty = 0.
- WAIT_STATES=3: read adr 0x10 -> ack exactly 4 cycles after the accept edge, high for 1 cycle only; tgd_o = the tga driven at accept.
- Byte lanes: write 0x11223344 with sel=1111, then write 0xAABBCCDD with sel=0101, then read -> 0x11BB33DD.
- Errors (DEPTH=256): adr 0x402 -> err in 1 cycle; adr 0x400 -> err; RAM unchanged, ack never asserted.
- Abort (WAIT_STATES=5): write 0x55 to adr 0x20, drop cyc 2 cycles after accept -> no ack/err; a later read of 0x20 returns the old value.
- WB_RAM_RTY_EN: busy_i=1 on a write to adr 0x0 -> rty pulse, no write; the same write retried with busy_i=0 -> ack, and a read returns the new data. Separately, rst_i asserted during WAIT -> all outputs 0 and no response.

Source files
------------

// File: rtl/wishbone_ram_slave.sv
// wishbone_ram_slave
//   Word-organised RAM endpoint for one slave port of the wishbone interconnect.
//   It handles single classic-cycle reads and writes and inserts WAIT_STATES idle
//   cycles before the response. Every accepted transfer ends with exactly one
//   registered ACK, ERR or RTY pulse. Addresses arrive relative to the slave base.
//
//   Optional build macro: WB_RAM_RTY_EN. When it is defined, the busy_i port
//   exists and a busy RAM answers with RTY. When it is undefined, busy_i is
//   absent and wb_rty_o is tied to 0.
//
//   Ports
//     clk_i, rst_i    clock; asynchronous active-high reset
//     wb_dat_i        write data
//     wb_tgd_i        write-data tag (ignored)
//     wb_adr_i        byte address, relative to the slave base
//     wb_tga_i        address tag, captured on accept
//     wb_cyc_i        cycle in progress
//     wb_tgc_i        cycle tag (ignored)
//     wb_sel_i        byte lane enables
//     wb_stb_i        strobe
//     wb_we_i         1 = write, 0 = read
//     busy_i          RAM unavailable (WB_RAM_RTY_EN only)
//     wb_dat_o        read data, valid only during an ACK of a read
//     wb_tgd_o        read-data tag, equal to the captured wb_tga_i
//     wb_ack_o        normal termination
//     wb_err_o        error termination
//     wb_rty_o        retry termination
//
//   FSM
//     state   | meaning
//     IDLE    | waiting for cyc & stb
//     WAIT    | counting down wait states; a dropped cyc aborts the transfer
//     RESP    | one-cycle ACK/ERR/RTY pulse
module wishbone_ram_slave #(
  parameter int TAGSIZE     = 1,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [TAGSIZE-1:0] wb_tgd_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [TAGSIZE-1:0] wb_tga_i,
  input  logic               wb_cyc_i,
  input  logic [TAGSIZE-1:0] wb_tgc_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
`ifdef WB_RAM_RTY_EN
  input  logic               busy_i,
`endif
  output logic [31:0]        wb_dat_o,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;

  logic          cap_we;
  logic [3:0]    cap_sel;
  logic [31:0]   cap_dat;
  logic [AW-1:0] cap_idx;

  logic          accept;
  logic          req_err;
  logic          req_rty;
  logic          enter_resp;    // a good access completes on this edge
  logic          resp_err;
  logic          resp_rty;
  logic          acc_we;
  logic [3:0]    acc_sel;
  logic [31:0]   acc_dat;
  logic [AW-1:0] acc_idx;

  logic [31:0]   mem [DEPTH];

  logic unused_tags;
  assign unused_tags = ^{wb_tgd_i, wb_tgc_i};

  assign accept  = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign req_err = (wb_adr_i[1:0] != 2'b00) ||
                   ({2'b00, wb_adr_i[31:2]} >= 32'(DEPTH));

`ifdef WB_RAM_RTY_EN
  assign req_rty = busy_i;
`else
  assign req_rty = 1'b0;
`endif

  // The access parameters come straight from the bus when the response follows
  // the accept directly, and from the capture registers after wait states.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    resp_err   = 1'b0;
    resp_rty   = 1'b0;
    acc_we     = cap_we;
    acc_sel    = cap_sel;
    acc_dat    = cap_dat;
    acc_idx    = cap_idx;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          acc_we  = wb_we_i;
          acc_sel = wb_sel_i;
          acc_dat = wb_dat_i;
          acc_idx = wb_adr_i[AW+1:2];
          if (req_err) begin
            resp_err  = 1'b1;
            state_nxt = ST_RESP;
          end else if (req_rty) begin
            resp_rty  = 1'b1;
            state_nxt = ST_RESP;
          end else if (WAIT_STATES == 0) begin
            enter_resp = 1'b1;
            state_nxt  = ST_RESP;
          end else begin
            cnt_nxt   = 4'(WAIT_STATES - 1);
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 4'd0) begin
          enter_resp = 1'b1;
          state_nxt  = ST_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      cap_we   <= 1'b0;
      cap_sel  <= 4'd0;
      cap_dat  <= 32'd0;
      cap_idx  <= '0;
      wb_tgd_o <= '0;
      wb_dat_o <= 32'd0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (accept) begin
        cap_we   <= wb_we_i;
        cap_sel  <= wb_sel_i;
        cap_dat  <= wb_dat_i;
        cap_idx  <= wb_adr_i[AW+1:2];
        wb_tgd_o <= wb_tga_i;
      end
      wb_ack_o <= enter_resp;
      wb_err_o <= resp_err;
      wb_dat_o <= (enter_resp && !acc_we) ? mem[acc_idx] : 32'd0;
    end
  end

`ifdef WB_RAM_RTY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wb_rty_o <= 1'b0;
    else       wb_rty_o <= resp_rty;
  end
`else
  assign wb_rty_o = 1'b0;
  logic unused_rty;
  assign unused_rty = resp_rty;
`endif

  // RAM contents are not reset. The write is gated by rst_i so that an edge
  // that arrives while reset is held can never commit a write.
  always_ff @(posedge clk_i) begin
    if (enter_resp && acc_we && !rst_i) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_sel[k]) mem[acc_idx][8*k +: 8] <= acc_dat[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wishbone_ram_slave.sv
module tb_wishbone_ram_slave;

  localparam int DEPTH = 256;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [31:0] dat_i = '0;
  logic [31:0] adr_i = '0;
  logic [3:0]  sel_i = '0;
  logic        we_i  = 1'b0;
  logic [0:0]  tga_i = '0;
  logic [0:0]  tgd_i = '0;
  logic [0:0]  tgc_i = '0;
  logic        busy_i = 1'b0;

  logic        cyc [3] = '{default: 1'b0};
  logic        stb [3] = '{default: 1'b0};
  logic [31:0] dat_o [3];
  logic [0:0]  tgd_o [3];
  logic        ack [3];
  logic        err [3];
  logic        rty [3];

  // Three instances with WAIT_STATES 0, 3 and 5. Each has its own cyc/stb,
  // so only the addressed instance sees a request.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wishbone_ram_slave #(
      .TAGSIZE(1),
      .DEPTH(DEPTH),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 5)
    ) u_dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wb_dat_i (dat_i),
      .wb_tgd_i (tgd_i),
      .wb_adr_i (adr_i),
      .wb_tga_i (tga_i),
      .wb_cyc_i (cyc[g]),
      .wb_tgc_i (tgc_i),
      .wb_sel_i (sel_i),
      .wb_stb_i (stb[g]),
      .wb_we_i  (we_i),
`ifdef WB_RAM_RTY_EN
      .busy_i   (busy_i),
`endif
      .wb_dat_o (dat_o[g]),
      .wb_tgd_o (tgd_o[g]),
      .wb_ack_o (ack[g]),
      .wb_err_o (err[g]),
      .wb_rty_o (rty[g])
    );
  end

  typedef struct {
    logic [2:0]  kind;   // {ack, err, rty}
    logic [31:0] dat;
    logic [0:0]  tag;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [3][DEPTH];
  int          checks = 0;
  int          errors = 0;

  function automatic int wsv(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input int d);
    check({tag, "_ack"}, 32'(ack[d]), 32'd0);
    check({tag, "_err"}, 32'(err[d]), 32'd0);
    check({tag, "_rty"}, 32'(rty[d]), 32'd0);
    check({tag, "_dat"}, dat_o[d], 32'd0);
  endtask

  // One complete transfer on instance d. The expectation is pushed to the
  // scoreboard when the request is driven and popped when the response arrives.
  task automatic xfer(input string tag, input int d, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdat, input logic [3:0] sel, input logic [0:0] tga,
                      input logic busy);
    exp_t e;
    exp_t got;
    int   n;
    int   w;
    e.tag = tga;
    e.dat = 32'd0;
    e.lat = 1;
    if (adr[1:0] != 2'b00 || adr >= 32'(DEPTH * 4)) begin
      e.kind = 3'b010;
    end else if (busy) begin
      e.kind = 3'b001;
    end else begin
      e.kind = 3'b100;
      e.lat  = wsv(d) + 1;
      w = int'(adr[9:2]);
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (sel[k]) model[d][w][8*k +: 8] = wdat[8*k +: 8];
      end else begin
        e.dat = model[d][w];
      end
    end
    sb.push_back(e);

    @(posedge clk_i); #1;
    adr_i  = adr;
    dat_i  = wdat;
    sel_i  = sel;
    we_i   = we;
    tga_i  = tga;
    busy_i = busy;
    cyc[d] = 1'b1;
    stb[d] = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!(ack[d] | err[d] | rty[d]) && n < 40);
    got = sb.pop_front();
    check({tag, "_kind"}, 32'({ack[d], err[d], rty[d]}), 32'(got.kind));
    check({tag, "_lat"},  32'(n), 32'(got.lat));
    check({tag, "_dat"},  dat_o[d], got.dat);
    check({tag, "_tgd"},  32'(tgd_o[d]), 32'(got.tag));
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
    busy_i = 1'b0;
    @(posedge clk_i); #1;
    check({tag, "_pulse"}, 32'({ack[d], err[d], rty[d]}), 32'd0);
  endtask

  // Write on instance d that is abandoned two cycles after acceptance, either
  // by dropping cyc or by asserting reset. No response may follow.
  task automatic abandoned_write(input string tag, input int d, input logic [31:0] adr,
                                 input logic [31:0] wdat, input logic use_reset);
    logic seen;
    @(posedge clk_i); #1;
    adr_i  = adr;
    dat_i  = wdat;
    sel_i  = 4'hF;
    we_i   = 1'b1;
    tga_i  = 1'b1;
    cyc[d] = 1'b1;
    stb[d] = 1'b1;
    seen   = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      seen = seen | ack[d] | err[d] | rty[d];
    end
    if (use_reset) begin
      rst_i = 1'b1;
      #1;
      check({tag, "_rst_tgd"}, 32'(tgd_o[d]), 32'd0);
      check_quiet({tag, "_rst"}, d);
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
    end else begin
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
    end
    repeat (12) begin
      @(posedge clk_i); #1;
      seen = seen | ack[d] | err[d] | rty[d];
    end
    check({tag, "_noresp"}, 32'(seen), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_quiet("reset", d);
      check("reset_tgd", 32'(tgd_o[d]), 32'd0);
    end
    rst_i = 1'b0;

    // Basic write/read with no wait states.
    xfer("ws0_wr",   0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    xfer("ws0_rd",   0, 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b0);

    // Three wait states; the response tag echoes tga.
    xfer("ws3_wr",   1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    xfer("ws3_rd",   1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b1, 1'b0);
    xfer("ws3_err",  1, 1'b0, 32'h404, 32'h0,       4'hF, 1'b1, 1'b0);

    // Byte lanes, an empty sel mask and the last word.
    xfer("lane_wr1", 0, 1'b1, 32'h14, 32'h11223344, 4'hF, 1'b0, 1'b0);
    xfer("lane_wr2", 0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
    xfer("lane_rd",  0, 1'b0, 32'h14, 32'h0,        4'h2, 1'b0, 1'b0);
    xfer("sel0_wr",  0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
    xfer("sel0_rd",  0, 1'b0, 32'h14, 32'h0,        4'hF, 1'b1, 1'b0);
    xfer("last_wr",  0, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
    xfer("last_rd",  0, 1'b0, 32'h3FC, 32'h0,       4'hF, 1'b0, 1'b0);

    // Misaligned and out-of-range addresses; RAM must be untouched.
    xfer("err_402",  0, 1'b1, 32'h402, 32'h12345678, 4'hF, 1'b1, 1'b0);
    xfer("err_400",  0, 1'b1, 32'h400, 32'h12345678, 4'hF, 1'b0, 1'b0);
    xfer("err_013",  0, 1'b1, 32'h13, 32'h12345678, 4'hF, 1'b1, 1'b0);
    xfer("err_chk",  0, 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b0);

    // Abort in WAIT by dropping cyc on the five-wait-state instance.
    xfer("ws5_wr",   2, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 1'b0);
    abandoned_write("abort", 2, 32'h20, 32'h00000055, 1'b0);
    xfer("abort_rd", 2, 1'b0, 32'h20, 32'h0,        4'hF, 1'b1, 1'b0);

`ifdef WB_RAM_RTY_EN
    xfer("rty_wr",   0, 1'b1, 32'h0, 32'h76543210, 4'hF, 1'b1, 1'b1);
    xfer("rty_rd0",  0, 1'b0, 32'h0, 32'h0,        4'hF, 1'b0, 1'b0);
    xfer("retry_wr", 0, 1'b1, 32'h0, 32'h76543210, 4'hF, 1'b1, 1'b0);
    xfer("retry_rd", 0, 1'b0, 32'h0, 32'h0,        4'hF, 1'b0, 1'b0);
    xfer("rty_err",  0, 1'b0, 32'h401, 32'h0,      4'hF, 1'b1, 1'b1);
`endif

    // Reset while in WAIT: nothing is committed and no response follows.
    xfer("ws5_wr24", 2, 1'b1, 32'h24, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0);
    abandoned_write("rstmid", 2, 32'h24, 32'h5A5A5A5A, 1'b1);
    xfer("rstmid_rd", 2, 1'b0, 32'h24, 32'h0,       4'hF, 1'b1, 1'b0);
    xfer("post_rst_ws0", 0, 1'b0, 32'h14, 32'h0,    4'hF, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
